clk_switch_ctrl: RTL and testbench

Single-clock sequencer that arbitrates clock-source change requests from several requesters and drives the `select` input of the glitch-free two-source clock switch. It accepts one request at a time, moves `select`, waits a programmable settle window and acknowledges the winner. An optional minimum dwell keeps `select` from toggling faster than the switch can safely hand over. It runs in the always-on control clock domain, upstream of the switch.

---
 rtl/clk_switch_ctrl_pkg.sv | 21 ++
 rtl/clk_switch_prio_arb.sv | 25 ++
 rtl/clk_switch_ctrl.sv | 134 +++++++++++++
 tb/tb_clk_switch_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/clk_switch_ctrl_pkg.sv
// Shared types and constants for the clock-switch select sequencer.
// Optional feature macro: CLK_SWITCH_CTRL_DWELL_EN (adds the post-switch DWELL hold).
package clk_switch_ctrl_pkg;

   // Sequencer states; StDwell is only reachable when the dwell hold is built in.
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSettle = 2'd1,
      StDwell  = 2'd2
   } clksw_state_t;

   // Encoding of the select line driven to the glitch-free switch.
   localparam logic CLKSW_SRC0 = 1'b0;
   localparam logic CLKSW_SRC1 = 1'b1;

   // Larger of two cycle counts, used to size the shared settle/dwell counter.
   function automatic int unsigned clksw_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/clk_switch_prio_arb.sv
// Combinational fixed-priority arbiter: the lowest set request index wins.
// Optional feature macro: none (used unchanged with or without CLK_SWITCH_CTRL_DWELL_EN).
module clk_switch_prio_arb #(
   parameter int unsigned NREQ = 2
) (
   input  logic [NREQ-1:0] req_i,
   output logic [NREQ-1:0] gnt_o,
   output logic            found_o
);

   // Scan from index 0 upward and stop granting after the first hit.
   always_comb begin
      logic hit;
      hit   = 1'b0;
      gnt_o = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (req_i[i] && !hit) begin
            gnt_o[i] = 1'b1;
            hit      = 1'b1;
         end
      end
      found_o = hit;
   end

endmodule

// File: rtl/clk_switch_ctrl.sv
// Clock-source change sequencer: arbitrates requests, moves select, waits a settle
// window, then acknowledges the winner.
// Optional feature macro: CLK_SWITCH_CTRL_DWELL_EN adds a DWELL hold after each switch
// so select cannot toggle faster than the downstream switch can hand over.
module clk_switch_ctrl
   import clk_switch_ctrl_pkg::*;
#(
   parameter int unsigned NREQ          = 2,
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned DWELL_CYCLES  = 32,
   parameter logic        RESET_SEL     = CLKSW_SRC0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [NREQ-1:0] req_valid_i,
   input  logic [NREQ-1:0] req_sel_i,
   output logic [NREQ-1:0] ack_o,
   output logic            select_o,
   output logic            busy_o
);

   localparam int unsigned CntMax = clksw_max(SETTLE_CYCLES, DWELL_CYCLES);
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam int unsigned IdxW   = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);
`ifdef CLK_SWITCH_CTRL_DWELL_EN
   localparam logic [CntW-1:0] DwellLoad  = CntW'(DWELL_CYCLES - 1);
`endif

   clksw_state_t    state_q;
   logic [CntW-1:0] cnt_q;
   logic [IdxW-1:0] grant_q;
   logic [NREQ-1:0] ack_q;
   logic            select_q;
   logic            busy_q;

   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] gnt;
   logic            found;
   logic [IdxW-1:0] gnt_idx;
   logic            win_sel;

   // A requester seeing its own ack this cycle is masked so it is not served twice.
   assign eligible = req_valid_i & ~ack_q;

   clk_switch_prio_arb #(
      .NREQ(NREQ)
   ) u_arb (
      .req_i  (eligible),
      .gnt_o  (gnt),
      .found_o(found)
   );

   // Encode the one-hot grant and pick out the winner's requested source.
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (gnt[i]) begin
            gnt_idx = IdxW'(i);
         end
      end
      win_sel = |(gnt & req_sel_i);
   end

   // Sequencer FSM with counter and all output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         grant_q  <= '0;
         ack_q    <= '0;
         select_q <= RESET_SEL;
         busy_q   <= 1'b0;
      end else begin
         ack_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (found) begin
                  if (win_sel == select_q) begin
                     // Already on the requested source: acknowledge without switching.
                     ack_q <= gnt;
                  end else begin
                     select_q <= win_sel;
                     cnt_q    <= SettleLoad;
                     grant_q  <= gnt_idx;
                     state_q  <= StSettle;
                     busy_q   <= 1'b1;
                  end
               end
            end
            StSettle: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CntW'(1);
               end else begin
                  // An abandoned request still completes the switch but gets no ack.
                  if (req_valid_i[grant_q]) begin
                     ack_q[grant_q] <= 1'b1;
                  end
`ifdef CLK_SWITCH_CTRL_DWELL_EN
                  cnt_q   <= DwellLoad;
                  state_q <= StDwell;
`else
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
`endif
               end
            end
            StDwell: begin
`ifdef CLK_SWITCH_CTRL_DWELL_EN
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CntW'(1);
               end else begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
`else
               state_q <= StIdle;
               busy_q  <= 1'b0;
`endif
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ack_o    = ack_q;
   assign select_o = select_q;
   assign busy_o   = busy_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed self-checking bench for clk_switch_ctrl (NREQ=2, SETTLE=16, DWELL=32).
// Honours CLK_SWITCH_CTRL_DWELL_EN to expect the extra post-switch hold.
module tb_clk_switch_ctrl;

   localparam int unsigned Settle = 16;
`ifdef CLK_SWITCH_CTRL_DWELL_EN
   localparam int unsigned Hold = 32;
`else
   localparam int unsigned Hold = 0;
`endif
   localparam logic BusyAfterSettle = (Hold > 0);

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req_valid;
   logic [1:0] req_sel;
   logic [1:0] ack;
   logic       select;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   clk_switch_ctrl #(
      .NREQ         (2),
      .SETTLE_CYCLES(Settle),
      .DWELL_CYCLES (32),
      .RESET_SEL    (1'b0)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_valid_i(req_valid),
      .req_sel_i  (req_sel),
      .ack_o      (ack),
      .select_o   (select),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, leaving time 1 unit after the last edge.
   task automatic tick(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 2'b00;
      req_sel   = 2'b00;

      // Reset values.
      #2;
      check("rst_select", 32'(select), 32'd0);
      check("rst_busy",   32'(busy),   32'd0);
      check("rst_ack",    32'(ack),    32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      check("idle_select", 32'(select), 32'd0);
      check("idle_busy",   32'(busy),   32'd0);

      // First switch: requester 0 to clk1.
      req_valid = 2'b01;
      req_sel   = 2'b01;
      tick(1);
      check("sw1_e0_select", 32'(select), 32'd1);
      check("sw1_e0_busy",   32'(busy),   32'd1);
      check("sw1_e0_ack",    32'(ack),    32'd0);
      tick(Settle - 1);
      check("sw1_e15_ack",  32'(ack),  32'd0);
      check("sw1_e15_busy", 32'(busy), 32'd1);
      tick(1);
      check("sw1_ack",        32'(ack),    32'b01);
      check("sw1_ack_select", 32'(select), 32'd1);
      check("sw1_ack_busy",   32'(busy),   32'(BusyAfterSettle));
      req_valid = 2'b00;
      tick(1);
      check("sw1_ack_pulse", 32'(ack), 32'd0);
      tick(Hold);
      check("sw1_idle_busy", 32'(busy), 32'd0);

      // Abandoned request: requester 1 to clk0, dropped during SETTLE.
      req_valid = 2'b10;
      req_sel   = 2'b00;
      tick(1);
      check("ab_e0_select", 32'(select), 32'd0);
      check("ab_e0_busy",   32'(busy),   32'd1);
      tick(4);
      req_valid = 2'b00;
      tick(11);
      check("ab_e15_busy", 32'(busy), 32'd1);
      tick(1);
      check("ab_noack",  32'(ack),    32'd0);
      check("ab_select", 32'(select), 32'd0);
      check("ab_busy",   32'(busy),   32'(BusyAfterSettle));
      tick(Hold);
      check("ab_idle_busy", 32'(busy), 32'd0);
      check("ab_idle_ack",  32'(ack),  32'd0);

      // Same-source request from requester 1 (select already 0).
      req_valid = 2'b10;
      req_sel   = 2'b00;
      tick(1);
      check("same_ack",    32'(ack),    32'b10);
      check("same_select", 32'(select), 32'd0);
      check("same_busy",   32'(busy),   32'd0);
      tick(1);
      check("same_masked", 32'(ack),  32'd0);
      check("same_busy2",  32'(busy), 32'd0);
      req_valid = 2'b00;
      tick(1);
      check("same_quiet", 32'(ack), 32'd0);

      // Priority plus back-to-back opposite request.
      req_valid = 2'b11;
      req_sel   = 2'b01;
      tick(1);
      check("pri_e0_select", 32'(select), 32'd1);
      check("pri_e0_busy",   32'(busy),   32'd1);
      tick(Settle);
      check("pri_ack0",        32'(ack),    32'b01);
      check("pri_ack0_select", 32'(select), 32'd1);
      req_valid = 2'b10;
      tick(Hold);
      check("pri_hold_select", 32'(select), 32'd1);
      tick(1);
      check("pri_sw2_select", 32'(select), 32'd0);
      check("pri_sw2_busy",   32'(busy),   32'd1);
      tick(Settle);
      check("pri_ack1",        32'(ack),    32'b10);
      check("pri_ack1_select", 32'(select), 32'd0);
      req_valid = 2'b00;
      tick(1);
      check("pri_ack1_pulse", 32'(ack), 32'd0);
      tick(Hold);
      check("pri_idle_busy", 32'(busy), 32'd0);

      // Reset mid-switch, then re-arbitration of the still-pending request.
      req_valid = 2'b01;
      req_sel   = 2'b01;
      tick(1);
      check("mid_e0_select", 32'(select), 32'd1);
      tick(3);
      rst_n = 1'b0;
      #1;
      check("mid_rst_select", 32'(select), 32'd0);
      check("mid_rst_busy",   32'(busy),   32'd0);
      check("mid_rst_ack",    32'(ack),    32'd0);
      #3;
      rst_n = 1'b1;
      tick(1);
      check("mid_rearb_select", 32'(select), 32'd1);
      check("mid_rearb_busy",   32'(busy),   32'd1);
      tick(Settle);
      check("mid_ack", 32'(ack), 32'b01);
      req_valid = 2'b00;
      tick(1 + Hold);
      check("mid_idle_busy", 32'(busy), 32'd0);
      check("mid_idle_ack",  32'(ack),  32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
